alu_ctrl_stage: RTL and testbench

//  Producer side of the ALU's 4-bit control interface. Decodes the opcode/funct of the instruction leaving
//  ID into the ALU control code and registers it into the ID/EX pipeline register that drives the ALU.

---
 rtl/alu_ctrl_pkg.sv | 57 +++++
 rtl/alu_ctrl_if.sv | 37 +++
 rtl/alu_ctrl_decode.sv | 45 ++++
 rtl/alu_ctrl_stage.sv | 73 +++++++
 tb/tb_alu_ctrl_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALU control codes, MIPS opcode/funct values and the
// stage-register bundles shared by the ALU control stage.
package alu_ctrl_pkg;

    typedef logic [3:0] alu_code_t;
    typedef logic [5:0] op_t;

    localparam alu_code_t ALU_AND = 4'b0000;
    localparam alu_code_t ALU_OR  = 4'b0001;
    localparam alu_code_t ALU_ADD = 4'b0010;
    localparam alu_code_t ALU_SUB = 4'b0110;
    localparam alu_code_t ALU_SLT = 4'b0111;
    localparam alu_code_t ALU_NOR = 4'b1100;

    localparam op_t OP_RTYPE = 6'h00;
    localparam op_t OP_J     = 6'h02;
    localparam op_t OP_BEQ   = 6'h04;
    localparam op_t OP_BNE   = 6'h05;
    localparam op_t OP_ADDI  = 6'h08;
    localparam op_t OP_ADDIU = 6'h09;
    localparam op_t OP_SLTI  = 6'h0A;
    localparam op_t OP_ANDI  = 6'h0C;
    localparam op_t OP_ORI   = 6'h0D;
    localparam op_t OP_LW    = 6'h23;
    localparam op_t OP_SW    = 6'h2B;

    localparam op_t FN_ADD  = 6'h20;
    localparam op_t FN_ADDU = 6'h21;
    localparam op_t FN_SUB  = 6'h22;
    localparam op_t FN_SUBU = 6'h23;
    localparam op_t FN_AND  = 6'h24;
    localparam op_t FN_OR   = 6'h25;
    localparam op_t FN_NOR  = 6'h27;
    localparam op_t FN_SLT  = 6'h2A;

    typedef struct packed {
        alu_code_t ctrl;
        logic      is_beq;
        logic      is_bne;
        logic      illegal;
    } dec_t;

    typedef struct packed {
        logic      valid;
        alu_code_t ctrl;
        logic      is_beq;
        logic      is_bne;
        logic      illegal;
    } ex_t;

    typedef struct packed {
        logic valid;
        logic taken;
        logic illegal;
    } mem_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Decode-side inputs plus EX/MEM outputs of the ALU control stage.
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic      id_valid;
    op_t       id_opcode;
    op_t       id_funct;
    logic      stall;
    logic      flush;
    logic      ex_valid;
    alu_code_t ex_alu_control;
    logic      ex_is_beq;
    logic      ex_is_bne;
    logic      alu_zero;
    logic      mem_valid;
    logic      mem_branch_taken;
    logic      mem_illegal;

    modport master (
        output id_valid, id_opcode, id_funct,
        output stall, flush, alu_zero,
        input  ex_valid, ex_alu_control,
        input  ex_is_beq, ex_is_bne,
        input  mem_valid, mem_branch_taken,
        input  mem_illegal
    );

    modport slave (
        input  id_valid, id_opcode, id_funct,
        input  stall, flush, alu_zero,
        output ex_valid, ex_alu_control,
        output ex_is_beq, ex_is_bne,
        output mem_valid, mem_branch_taken,
        output mem_illegal
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control,
// branch kind and an illegal-instruction flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter alu_code_t BUBBLE_CTRL = ALU_ADD
) (
    input  op_t  opcode_i,
    input  op_t  funct_i,
    output dec_t dec_o
);

    always_comb begin
        dec_o = '{ctrl: BUBBLE_CTRL, is_beq: 1'b0,
                  is_bne: 1'b0, illegal: 1'b0};
        unique case (opcode_i)
            OP_RTYPE: begin
                unique case (funct_i)
                    FN_ADD, FN_ADDU: dec_o.ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_o.ctrl = ALU_SUB;
                    FN_AND:          dec_o.ctrl = ALU_AND;
                    FN_OR:           dec_o.ctrl = ALU_OR;
                    FN_NOR:          dec_o.ctrl = ALU_NOR;
                    FN_SLT:          dec_o.ctrl = ALU_SLT;
                    default:         dec_o.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_J:
                dec_o.ctrl = ALU_ADD;
            OP_ANDI: dec_o.ctrl = ALU_AND;
            OP_ORI:  dec_o.ctrl = ALU_OR;
            OP_SLTI: dec_o.ctrl = ALU_SLT;
            OP_BEQ: begin
                dec_o.ctrl   = ALU_SUB;
                dec_o.is_beq = 1'b1;
            end
            OP_BNE: begin
                dec_o.ctrl   = ALU_SUB;
                dec_o.is_bne = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU-control register and EX/MEM branch-resolution
// register of the pipelined MIPS core.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter alu_code_t BUBBLE_CTRL = 4'b0010
) (
    input logic      clk,
    input logic      reset,
    alu_ctrl_if.slave bus
);

    localparam ex_t EX_BUBBLE = '{valid: 1'b0,
                                  ctrl: BUBBLE_CTRL,
                                  is_beq: 1'b0,
                                  is_bne: 1'b0,
                                  illegal: 1'b0};

    dec_t dec;
    ex_t  ex_q, ex_d;
    mem_t mem_q, mem_d;

    alu_ctrl_decode #(
        .BUBBLE_CTRL(BUBBLE_CTRL)
    ) u_decode (
        .opcode_i(bus.id_opcode),
        .funct_i (bus.id_funct),
        .dec_o   (dec)
    );

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (bus.flush) begin
            ex_d  = EX_BUBBLE;
            mem_d = '0;
        end else if (!bus.stall) begin
            if (bus.id_valid) begin
                ex_d = '{valid: 1'b1, ctrl: dec.ctrl,
                         is_beq: dec.is_beq,
                         is_bne: dec.is_bne,
                         illegal: dec.illegal};
            end else begin
                ex_d = EX_BUBBLE;
            end
            // alu_zero belongs to the instruction in EX now
            mem_d.valid   = ex_q.valid;
            mem_d.taken   = ex_q.valid &
                            ((ex_q.is_beq & bus.alu_zero) |
                             (ex_q.is_bne & ~bus.alu_zero));
            mem_d.illegal = ex_q.valid & ex_q.illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign bus.ex_valid         = ex_q.valid;
    assign bus.ex_alu_control   = ex_q.ctrl;
    assign bus.ex_is_beq        = ex_q.is_beq;
    assign bus.ex_is_bne        = ex_q.is_bne;
    assign bus.mem_valid        = mem_q.valid;
    assign bus.mem_branch_taken = mem_q.taken;
    assign bus.mem_illegal      = mem_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed vector table, corner sequences and a full
// opcode x funct sweep for alu_ctrl_stage.
module tb_alu_ctrl_stage;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    alu_ctrl_if bus ();

    alu_ctrl_stage #(
        .BUBBLE_CTRL(4'b0010)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic       st;
        logic       fl;
        logic       z;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [5:0] op,
                       input logic [5:0] fn, input logic st,
                       input logic fl, input logic z,
                       input logic [9:0] exp);
        vec_t t;
        t.v = v; t.op = op; t.fn = fn;
        t.st = st; t.fl = fl; t.z = z; t.exp = exp;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h",
                      name, act, exp);
    endtask

    function automatic logic [9:0] outs();
        return {bus.ex_valid, bus.ex_alu_control,
                bus.ex_is_beq, bus.ex_is_bne,
                bus.mem_valid, bus.mem_branch_taken,
                bus.mem_illegal};
    endfunction

    // {ctrl, beq, bne, illegal} straight from the decode table
    function automatic logic [6:0] model(input logic [5:0] op,
                                         input logic [5:0] fn);
        logic [6:0] r;
        r = {4'b0010, 3'b001};
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: r = {4'b0010, 3'b000};
                6'h22, 6'h23: r = {4'b0110, 3'b000};
                6'h24:        r = {4'b0000, 3'b000};
                6'h25:        r = {4'b0001, 3'b000};
                6'h27:        r = {4'b1100, 3'b000};
                6'h2A:        r = {4'b0111, 3'b000};
                default:      r = {4'b0010, 3'b001};
            endcase
            6'h08, 6'h09, 6'h23, 6'h2B, 6'h02:
                r = {4'b0010, 3'b000};
            6'h0C: r = {4'b0000, 3'b000};
            6'h0D: r = {4'b0001, 3'b000};
            6'h0A: r = {4'b0111, 3'b000};
            6'h04: r = {4'b0110, 3'b100};
            6'h05: r = {4'b0110, 3'b010};
            default: r = {4'b0010, 3'b001};
        endcase
        return r;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [5:0] fn, input logic st,
                         input logic fl, input logic z);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_funct  = fn;
        bus.stall     = st;
        bus.flush     = fl;
        bus.alu_zero  = z;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] m;
        logic [6:0] pm;
        logic       pz;
        logic       first;
        logic [3:0] c;
        n_pass  = 0;
        n_total = 0;

        // exv ctrl beq bne | memv taken ill
        add(1, 6'h00, 6'h2A, 0, 0, 0, 10'b1_0111_00_000);
        add(1, 6'h04, 6'h00, 0, 0, 0, 10'b1_0110_10_100);
        add(1, 6'h05, 6'h00, 0, 0, 1, 10'b1_0110_01_110);
        add(1, 6'h00, 6'h08, 0, 0, 1, 10'b1_0010_00_100);
        add(0, 6'h00, 6'h00, 0, 0, 0, 10'b0_0010_00_101);
        add(1, 6'h0C, 6'h00, 0, 0, 0, 10'b1_0000_00_000);
        add(0, 6'h3F, 6'h3F, 1, 0, 1, 10'b1_0000_00_000);
        add(0, 6'h3F, 6'h3F, 1, 0, 1, 10'b1_0000_00_000);
        add(0, 6'h3F, 6'h3F, 1, 0, 1, 10'b1_0000_00_000);
        add(1, 6'h0D, 6'h00, 0, 0, 0, 10'b1_0001_00_100);
        add(1, 6'h04, 6'h00, 0, 0, 0, 10'b1_0110_10_100);
        add(1, 6'h05, 6'h00, 1, 1, 1, 10'b0_0010_00_000);
        add(1, 6'h04, 6'h00, 0, 0, 0, 10'b1_0110_10_000);
        add(1, 6'h0A, 6'h00, 0, 0, 1, 10'b1_0111_00_110);
        add(0, 6'h00, 6'h00, 1, 0, 0, 10'b1_0111_00_110);
        add(1, 6'h2B, 6'h00, 0, 0, 0, 10'b1_0010_00_100);
        add(1, 6'h00, 6'h27, 0, 0, 0, 10'b1_1100_00_100);
        add(1, 6'h00, 6'h22, 0, 0, 0, 10'b1_0110_00_100);
        add(1, 6'h3F, 6'h00, 0, 0, 0, 10'b1_0010_00_100);
        add(0, 6'h00, 6'h00, 0, 0, 0, 10'b0_0010_00_101);
        add(1, 6'h05, 6'h00, 0, 0, 0, 10'b1_0110_01_000);
        add(0, 6'h00, 6'h00, 0, 0, 0, 10'b0_0010_00_110);
        add(1, 6'h04, 6'h00, 0, 0, 0, 10'b1_0110_10_000);
        add(1, 6'h00, 6'h20, 0, 1, 1, 10'b0_0010_00_000);
        add(1, 6'h23, 6'h00, 0, 0, 1, 10'b1_0010_00_000);

        drive(0, 6'h00, 6'h00, 0, 0, 0);
        reset = 1'b1;
        step();
        step();
        chk("reset_state", 32'(outs()), 32'(10'b0_0010_00_000));
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].fn,
                  vecs[i].st, vecs[i].fl, vecs[i].z);
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'(vecs[i].exp));
        end

        // reset mid-stream with a taken beq about to resolve
        drive(1, 6'h04, 6'h00, 0, 0, 0);
        step();
        chk("pre_reset_beq", 32'(outs()),
            32'(10'b1_0110_10_100));
        drive(1, 6'h04, 6'h00, 0, 0, 1);
        reset = 1'b1;
        step();
        chk("mid_reset", 32'(outs()), 32'(10'b0_0010_00_000));
        reset = 1'b0;
        drive(0, 6'h00, 6'h00, 0, 0, 1);
        step();
        chk("post_reset_no_taken", 32'(outs()),
            32'(10'b0_0010_00_000));

        // full decode sweep streamed through both stages
        first = 1'b1;
        pm    = '0;
        pz    = 1'b0;
        for (int op = 0; op < 64; op++) begin
            for (int fn = 0; fn < 64; fn++) begin
                pz = 1'($urandom_range(0, 1));
                drive(1, 6'(op), 6'(fn), 0, 0, pz);
                step();
                m = model(6'(op), 6'(fn));
                chk($sformatf("sweep_ex_%02h_%02h", op, fn),
                    32'({bus.ex_valid, bus.ex_alu_control,
                         bus.ex_is_beq, bus.ex_is_bne}),
                    32'({1'b1, m[6:1]}));
                c = bus.ex_alu_control;
                chk($sformatf("sweep_legal_%02h_%02h", op, fn),
                    32'(c inside {4'b0000, 4'b0001, 4'b0010,
                                  4'b0110, 4'b0111, 4'b1100}),
                    32'd1);
                if (!first) begin
                    chk($sformatf("sweep_mem_%02h_%02h", op, fn),
                        32'({bus.mem_valid,
                             bus.mem_branch_taken,
                             bus.mem_illegal}),
                        32'({1'b1,
                             (pm[2] & pz) | (pm[1] & ~pz),
                             pm[0]}));
                end
                first = 1'b0;
                pm    = m;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
